// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one full-adder step per cycle, LSB first.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res;
    logic             c_r;
    logic             s;
    logic             c_nxt;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // A-B as A + ~B + 1; carry-out of 1 means no borrow
    assign b_load = sub ? ~b_in : b_in;
    assign c_load = sub | cin;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_load     = b_in;
    assign c_load     = cin;
`endif

    assign s     = a_r[0] ^ b_r[0] ^ c_r;
    assign c_nxt = (a_r[0] & b_r[0]) | ((a_r[0] ^ b_r[0]) & c_r);
    assign last  = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            res     <= '0;
            c_r     <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            a_r <= a_in;
            b_r <= b_load;
            res <= '0;
            c_r <= c_load;
        end else if (busy) begin
            a_r <= a_r >> 1;
            b_r <= b_r >> 1;
            res <= {s, res[WIDTH-1:1]};
            c_r <= c_nxt;
            cnt <= last ? '0 : cnt + 1'b1;
            // final bit joins the result on the same edge it is published
            if (last) begin
                sum_out <= {s, res[WIDTH-1:1]};
                cout    <= c_nxt;
            end
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new addition; sampled only when accepted per REQ-012.
REQ-005 The block SHALL have port a_in, input, WIDTH bits: operand A, captured on start acceptance.
REQ-006 The block SHALL have port b_in, input, WIDTH bits: operand B, captured on start acceptance.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured on start acceptance.
REQ-008 The block SHALL have port sub, input, 1 bit: subtract select, captured on start acceptance; used only per REQ-024.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in SHIFT.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse when a result becomes valid.
REQ-011 The block SHALL have ports sum_out, output, WIDTH bits, and cout, output, 1 bit: last completed result and carry-out, held until the next completion.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; start=1 is accepted only in IDLE or DONE, and is ignored in SHIFT.
REQ-013 On acceptance (cycle 0), the block SHALL load a_in, b_in and cin into internal operand shift registers and the carry flop, then enter SHIFT.
REQ-014 In SHIFT, the block SHALL process one bit per cycle, LSB first, using full-adder logic: s = a^b^c and c_next = (a&b)|((a^b)&c); s shifts into an internal result register and c_next updates the carry flop.
REQ-015 A bit counter SHALL count 0..WIDTH-1; SHIFT SHALL last exactly WIDTH cycles (cycles 1..WIDTH), after which the FSM enters DONE.
REQ-016 On entry to DONE (cycle WIDTH+1), the block SHALL assert done=1, copy the internal result to sum_out and the final carry to cout, and drive busy=0.
REQ-017 DONE SHALL last exactly one cycle; it SHALL return to IDLE, or, if start=1 in DONE, re-enter SHIFT with new operands (back-to-back, with no IDLE gap).
REQ-018 busy SHALL be 1 exactly in cycles 1..WIDTH, and 0 otherwise.
REQ-019 sum_out and cout SHALL NOT change during SHIFT; they change only on the DONE entry edge.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH, with the carry beyond the MSB reported on cout; no overflow flag.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, sum_out, cout, the counter, the carry flop and the shift registers to 0.
REQ-022 Reset SHALL override start and SHALL abort any in-progress operation with no done pulse.
REQ-023 After rst_n returns high, start SHALL be accepted in the first cycle.

Configuration
REQ-024 When macro SERIAL_ADDER_SUB_EN is defined: if the captured sub=1, the block SHALL load ~b_in into the B register and force the carry flop to 1, ignoring cin, giving A-B (cout=1 means no borrow).
REQ-025 When SERIAL_ADDER_SUB_EN is undefined, the sub port SHALL exist but be ignored, and the block SHALL always add.

Verification (WIDTH=8)
REQ-026 A bench SHALL apply a_in=0x3C, b_in=0x0F, cin=0 with a start pulse and check done at cycle 9, sum_out=0x4B, cout=0, and busy high in cycles 1..8.
REQ-027 A bench SHALL apply 0xFF+0x01 with cin=0 and check sum_out=0x00, cout=1; and 0xFF+0xFF with cin=1 and check sum_out=0xFF, cout=1.
REQ-028 A bench SHALL assert start with new operands at cycle 4 of an operation and check that it is ignored and the first result is unchanged; it SHALL assert start in the DONE cycle and check that busy is high in the next cycle and the second done arrives 9 cycles later.
REQ-029 A bench SHALL drive rst_n=0 at cycle 5 of an operation and check that all outputs are 0 the next cycle, no done pulse occurs, and the next start completes normally.
REQ-030 With SERIAL_ADDER_SUB_EN defined, a bench SHALL apply sub=1, 0x05-0x07 and check sum_out=0xFE, cout=0; and 0x07-0x05 and check sum_out=0x02, cout=1. Without the macro, the same stimulus SHALL give 0x0C and 0x0C respectively, both with cout=0.
